// File: rtl/bsx_pkg.sv
// ============================================================================
// Module  : bsx_pkg
// Brief   : Shared widths, state encodings and fill byte for the BS-X stream fetch.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bsx_pkg;

   localparam int          BSX_KEY_W     = 19;
   localparam logic [7:0]  BSX_FILL_BYTE = 8'hFF;

   typedef enum logic [0:0] {
      BSX_IDLE = 1'b0,
      BSX_REQ  = 1'b1
   } bsx_state_t;

endpackage

`default_nettype wire

// File: rtl/bsx_stream_entry.sv
// ============================================================================
// Module  : bsx_stream_entry
// Brief   : One prefetched stream byte (valid/key/data) with its hit compare.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bsx_stream_entry
   import bsx_pkg::*;
(
   input  logic                 clkin,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [BSX_KEY_W-1:0] wr_key,
   input  logic [7:0]           wr_data,
   input  logic [BSX_KEY_W-1:0] lookup_key,
   output logic                 hit,
   output logic [7:0]           data
);

   logic                 r_valid;
   logic [BSX_KEY_W-1:0] r_key;
   logic [7:0]           r_data;

   always_ff @(posedge clkin) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_key   <= '0;
         r_data  <= BSX_FILL_BYTE;
      end else if (wr_en) begin
         r_valid <= 1'b1;
         r_key   <= wr_key;
         r_data  <= wr_data;
      end
   end

   assign hit  = r_valid && (r_key == lookup_key);
   assign data = r_data;

endmodule

`default_nettype wire

// File: rtl/bsx_stream_fetch.sv
// ============================================================================
// Module  : bsx_stream_fetch
// Brief   : Per-channel one-byte prefetch of BS-X stream data from cart RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bsx_stream_fetch
   import bsx_pkg::*;
#(
   parameter logic [23:0] STREAM_BASE = 24'hE00000,
   parameter logic [7:0]  TIMEOUT     = 8'd200
)
(
   input  logic        clkin,
   input  logic        reset,
   input  logic        bs_page_enable,
   input  logic        bs_chan,
   input  logic [9:0]  bs_page_out,
   input  logic [8:0]  bs_page_offset,
   input  logic        reg_oe_falling,
   output logic        mem_req,
   output logic [23:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  stream_data,
   output logic        stream_valid,
   output logic [7:0]  miss_count
);

   bsx_state_t           r_state, w_state_next;
   logic                 r_mem_req;
   logic [23:0]          r_mem_addr;
   logic [BSX_KEY_W-1:0] r_key;
   logic                 r_chan;
   logic [7:0]           r_count;
   logic [7:0]           r_miss;

   logic [BSX_KEY_W-1:0] w_key;
   logic [1:0]           w_hit_e;
   logic [7:0]           w_data_e [2];
   logic                 w_hit;
   logic                 w_launch;
   logic                 w_done;
   logic                 w_wr_en;
   logic [7:0]           w_wr_data;

   assign w_key = {bs_page_out, bs_page_offset};

   for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      bsx_stream_entry u_entry (
         .clkin      (clkin),
         .reset      (reset),
         .wr_en      (w_wr_en && (r_chan == gi[0])),
         .wr_key     (r_key),
         .wr_data    (w_wr_data),
         .lookup_key (w_key),
         .hit        (w_hit_e[gi]),
         .data       (w_data_e[gi])
      );
   end

   assign w_hit        = w_hit_e[bs_chan];
   assign stream_data  = w_hit ? w_data_e[bs_chan] : BSX_FILL_BYTE;
   assign stream_valid = bs_page_enable & w_hit;

   always_ff @(posedge clkin) begin
      if (reset) r_state <= BSX_IDLE;
      else       r_state <= w_state_next;
   end

   // Only the current channel's key is visible; if the SNES has moved to the
   // other channel, the latched channel's key is assumed unchanged.
   always_comb begin
      w_state_next = r_state;
      w_launch     = 1'b0;
      w_done       = 1'b0;
      w_wr_en      = 1'b0;
      w_wr_data    = mem_rdata;
      case (r_state)
         BSX_IDLE: begin
            if (bs_page_enable && !w_hit) begin
               w_launch     = 1'b1;
               w_state_next = BSX_REQ;
            end
         end
         BSX_REQ: begin
            if (mem_ack) begin
               w_done       = 1'b1;
               w_wr_en      = (bs_chan != r_chan) || (w_key == r_key);
               w_state_next = BSX_IDLE;
            end else if (r_count == TIMEOUT - 8'd1) begin
               w_done       = 1'b1;
               w_wr_en      = 1'b1;
               w_wr_data    = BSX_FILL_BYTE;
               w_state_next = BSX_IDLE;
            end
         end
         default: w_state_next = BSX_IDLE;
      endcase
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
         r_key      <= '0;
         r_chan     <= 1'b0;
         r_count    <= '0;
      end else if (w_launch) begin
         r_mem_req  <= 1'b1;
         r_mem_addr <= STREAM_BASE + {5'b0, w_key};
         r_key      <= w_key;
         r_chan     <= bs_chan;
         r_count    <= '0;
      end else if (w_done) begin
         r_mem_req  <= 1'b0;
      end else if (r_state == BSX_REQ) begin
         r_count    <= r_count + 8'd1;
      end
   end

   always_ff @(posedge clkin) begin
      if (reset)
         r_miss <= '0;
      else if (reg_oe_falling && bs_page_enable && !w_hit && (r_miss != 8'hFF))
         r_miss <= r_miss + 8'd1;
   end

   assign mem_req    = r_mem_req;
   assign mem_addr   = r_mem_addr;
   assign miss_count = r_miss;

endmodule

`default_nettype wire

// File: tb/tb_bsx_stream_fetch.sv
// ============================================================================
// Module  : tb_bsx_stream_fetch
// Brief   : Directed self-checking bench for bsx_stream_fetch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bsx_stream_fetch;

   logic        clkin = 1'b0;
   logic        reset;
   logic        bs_page_enable;
   logic        bs_chan;
   logic [9:0]  bs_page_out;
   logic [8:0]  bs_page_offset;
   logic        reg_oe_falling;
   logic        mem_req;
   logic [23:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic [7:0]  stream_data;
   logic        stream_valid;
   logic [7:0]  miss_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clkin = ~clkin;

   bsx_stream_fetch dut (
      .clkin          (clkin),
      .reset          (reset),
      .bs_page_enable (bs_page_enable),
      .bs_chan        (bs_chan),
      .bs_page_out    (bs_page_out),
      .bs_page_offset (bs_page_offset),
      .reg_oe_falling (reg_oe_falling),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .stream_data    (stream_data),
      .stream_valid   (stream_valid),
      .miss_count     (miss_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then let inputs/outputs settle away from the edge.
   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic set_key(input logic ch, input logic [9:0] pg, input logic [8:0] off);
      bs_chan        = ch;
      bs_page_out    = pg;
      bs_page_offset = off;
      #1;
   endtask

   // Miss on the current key, expect a request at addr, answer it with d.
   task automatic fill(input string tag, input logic [23:0] addr, input logic [7:0] d);
      tick();
      check({tag, "_req"}, 32'(mem_req), 32'd1);
      check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
      mem_ack = 1'b1; mem_rdata = d;
      tick();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      #1;
      check({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
      check({tag, "_valid"}, 32'(stream_valid), 32'd1);
      check({tag, "_data"}, 32'(stream_data), 32'(d));
   endtask

   initial begin
      int cyc;
      reset = 1'b1; bs_page_enable = 1'b0; bs_chan = 1'b0; bs_page_out = '0;
      bs_page_offset = '0; reg_oe_falling = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_valid", 32'(stream_valid), 32'd0);
      check("rst_data", 32'(stream_data), 32'hFF);
      check("rst_miss", 32'(miss_count), 32'd0);

      // 1: first fetch, page 001 offset 048
      bs_page_enable = 1'b1;
      set_key(1'b0, 10'h001, 9'h048);
      check("t1_nohit", 32'(stream_valid), 32'd0);
      fill("t1", 24'hE00248, 8'h5A);

      // 2: prefetch of next offset, with a read before the ack
      set_key(1'b0, 10'h001, 9'h049);
      check("t2_invalid", 32'(stream_valid), 32'd0);
      check("t2_ffdata", 32'(stream_data), 32'hFF);
      reg_oe_falling = 1'b1;
      tick();
      reg_oe_falling = 1'b0;
      #1;
      check("t2_miss", 32'(miss_count), 32'd1);
      check("t2_req", 32'(mem_req), 32'd1);
      check("t2_addr", 32'(mem_addr), 32'hE00249);
      mem_ack = 1'b1; mem_rdata = 8'h33;
      tick();
      mem_ack = 1'b0;
      #1;
      check("t2_valid", 32'(stream_valid), 32'd1);
      check("t2_data", 32'(stream_data), 32'h33);

      // 3: key changes while in REQ on channel 1 -> stale data discarded
      set_key(1'b1, 10'h001, 9'h048);
      tick();
      check("t3_addr0", 32'(mem_addr), 32'hE00248);
      set_key(1'b1, 10'h001, 9'h049);
      mem_ack = 1'b1; mem_rdata = 8'h11;
      tick();
      mem_ack = 1'b0;
      #1;
      check("t3_discard_valid", 32'(stream_valid), 32'd0);
      check("t3_discard_req", 32'(mem_req), 32'd0);
      fill("t3_refetch", 24'hE00249, 8'h22);

      // 4: no ack -> timeout after exactly 200 request cycles
      set_key(1'b0, 10'h001, 9'h050);
      tick();
      cyc = 0;
      while (mem_req && cyc < 400) begin
         cyc++;
         tick();
      end
      check("t4_req_cycles", 32'(cyc), 32'd200);
      check("t4_valid", 32'(stream_valid), 32'd1);
      check("t4_data", 32'(stream_data), 32'hFF);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_no_rereq", 32'(mem_req), 32'd0);
      end

      // 5: both channels filled, alternate with no new requests
      set_key(1'b0, 10'h002, 9'h032);
      fill("t5_c0", 24'hE00432, 8'hAA);
      set_key(1'b1, 10'h003, 9'h034);
      fill("t5_c1", 24'hE00634, 8'hBB);
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) set_key(1'b0, 10'h002, 9'h032);
         else            set_key(1'b1, 10'h003, 9'h034);
         check("t5_hit", 32'(stream_valid), 32'd1);
         check("t5_data", 32'(stream_data), (i % 2 == 0) ? 32'hAA : 32'hBB);
         tick();
         check("t5_noreq", 32'(mem_req), 32'd0);
      end

      // 6a: 300 reads on ever-changing keys -> miss_count saturates
      for (int i = 0; i < 300; i++) begin
         set_key(1'b0, 10'h100, 9'(i));
         reg_oe_falling = 1'b1;
         tick();
         reg_oe_falling = 1'b0;
         if (i == 99) check("t6_miss100", 32'(miss_count), 32'd101);
      end
      #1;
      check("t6_miss_sat", 32'(miss_count), 32'hFF);

      // 6b: reset in the middle of a fetch
      while (mem_req) tick();
      set_key(1'b0, 10'h005, 9'h000);
      tick();
      check("t6_inreq", 32'(mem_req), 32'd1);
      reset = 1'b1;
      tick();
      check("t6_rst_req", 32'(mem_req), 32'd0);
      check("t6_rst_addr", 32'(mem_addr), 32'd0);
      check("t6_rst_miss", 32'(miss_count), 32'd0);
      check("t6_rst_valid", 32'(stream_valid), 32'd0);
      check("t6_rst_data", 32'(stream_data), 32'hFF);
      reset = 1'b0;
      set_key(1'b0, 10'h002, 9'h032);
      check("t6_entry_cleared", 32'(stream_valid), 32'd0);
      bs_page_enable = 1'b0;
      tick();
      check("t6_disabled_noreq", 32'(mem_req), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
